alpha_rom_fetch: RTL and testbench
==================================

ALPHA_ROM_FETCH -- requirements
Module: alpha_rom_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output byte buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset_b  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  burst request, sampled only while busy=0.
REQ-005 SHALL have port base_addr  input  14  first ROM address of the burst.
REQ-006 SHALL have port len  input  5  burst length in bytes, 0..31.
REQ-007 SHALL have port A  output  14  registered address to the 16Kx8 ROM.
REQ-008 SHALL have port CS_b  output  1  registered ROM chip select, active-low.
REQ-009 SHALL have port OE_b  output  1  registered ROM output enable, active-low.
REQ-010 SHALL have port rom_data  input  8  ROM read data, registered in the ROM one edge after the address.
REQ-011 SHALL have ports out_data (output, 8), out_valid (output, 1), out_ready (input, 1) forming the byte stream.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), checksum (output, 8).

Function
REQ-013 SHALL implement states IDLE, FETCH, DRAIN; IDLE->FETCH on start with len!=0; FETCH->DRAIN when the last read issues; DRAIN->IDLE when the last byte is accepted.
REQ-014 SHALL treat start with len=0 as a no-op: no ROM read, done pulses the next cycle, state stays IDLE.
REQ-015 SHALL ignore start while busy=1; busy=1 in FETCH and DRAIN only.
REQ-016 SHALL issue a read by presenting CS_b=0, OE_b=0 and A for exactly one cycle per byte; CS_b=OE_b=1 in every non-issue cycle.
REQ-017 SHALL sample rom_data into the buffer at the end of the cycle following the issue cycle (fixed 2-edge read latency); back-to-back issues allowed.
REQ-018 SHALL issue only when buffer occupancy plus in-flight reads < FIFO_DEPTH; never overflows, never drops a byte.
REQ-019 SHALL increment A by 1 per issue, modulo 2^14 (0x3FFF wraps to 0x0000).
REQ-020 SHALL deliver bytes in address order; out_valid=1 whenever the buffer is non-empty; transfer occurs when out_valid & out_ready.
REQ-021 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL allow simultaneous buffer write and read in one cycle with occupancy unchanged; a byte written while empty is visible on out_valid the following cycle.
REQ-023 SHALL pulse done for one cycle the cycle after the final byte transfer, with busy=0 in that same cycle; start is accepted in that cycle.

Reset
REQ-024 SHALL, on reset_b=0 at any time including mid-burst, immediately force: state IDLE, A=0, CS_b=1, OE_b=1, out_valid=0, out_data=0, busy=0, done=0, checksum=0, buffer and in-flight count cleared.
REQ-025 SHALL discard any ROM data returning after reset release from a read issued before reset.

Configuration
REQ-026 SHALL, with ALPHA_ROM_FETCH_CHKSUM_EN defined, clear checksum at burst start and XOR each byte transferred on the stream into it; final value valid from the done cycle until the next accepted start.
REQ-027 SHALL, without ALPHA_ROM_FETCH_CHKSUM_EN, keep the checksum port present and tied to 0; all other behaviour identical.

Verification
REQ-028 SHALL verify: ROM mem[i]=i[7:0]; start, base_addr=0x0010, len=3, out_ready=1 -> reads at 0x0010,0x0011,0x0012 on consecutive cycles, stream 0x10,0x11,0x12, one done pulse, checksum 0x13 (CHKSUM_EN).
REQ-029 SHALL verify: base_addr=0x3FFE, len=4 -> A sequence 0x3FFE,0x3FFF,0x0000,0x0001; stream 0xFE,0xFF,0x00,0x01.
REQ-030 SHALL verify: len=10, out_ready=0 for 20 cycles -> exactly FIFO_DEPTH (4) reads issued, then stall with CS_b=1; out_data=first byte and stable; releasing out_ready completes all 10 bytes in order.
REQ-031 SHALL verify: reset_b pulsed low during FETCH of len=8 -> outputs at reset values that cycle; new burst len=2 afterwards yields exactly 2 correct bytes, no stale data.
REQ-032 SHALL verify: start with len=0 -> no CS_b=0 cycle, done one cycle later; start asserted while busy -> ignored, no extra reads.
REQ-033 SHALL verify: random out_ready (50%) over a len=31 burst -> 31 bytes in order, no duplicate or loss.

Source files
------------

// File: rtl/alpha_rom_fetch.sv
// rtl/alpha_rom_fetch.sv - burst reader for a registered 16Kx8 ROM feeding a byte stream
// Optional stream checksum enabled by defining ALPHA_ROM_FETCH_CHKSUM_EN.
module alpha_rom_fetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        start,
  input  logic [13:0] base_addr,
  input  logic [4:0]  len,
  output logic [13:0] A,
  output logic        CS_b,
  output logic        OE_b,
  input  logic [7:0]  rom_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  checksum
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state_q;
  logic [13:0] a_q;
  logic [13:0] next_addr_q;
  logic [4:0]  rem_q;
  logic        cs_b_q;
  logic        oe_b_q;
  logic        pend_q;
  logic        done_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          push;
  logic          pop;
  logic [CW:0]   level;
  logic          can_issue;
  logic          last_pop;

  // pend_q marks the cycle in which the ROM presents data for last cycle's issue.
  assign push      = pend_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;

  // Occupancy plus both pipeline stages must leave room for the new read.
  assign level     = {1'b0, count_q} + {{CW{1'b0}}, ~cs_b_q} + {{CW{1'b0}}, pend_q};
  assign can_issue = (level < (CW+1)'(FIFO_DEPTH));
  assign last_pop  = pop && (count_q == CW'(1)) && cs_b_q && !pend_q;

  assign A    = a_q;
  assign CS_b = cs_b_q;
  assign OE_b = oe_b_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      a_q         <= 14'h0000;
      next_addr_q <= 14'h0000;
      rem_q       <= 5'd0;
      cs_b_q      <= 1'b1;
      oe_b_q      <= 1'b1;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cs_b_q <= 1'b1;
      oe_b_q <= 1'b1;
      done_q <= 1'b0;
      pend_q <= ~cs_b_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              cs_b_q      <= 1'b0;
              oe_b_q      <= 1'b0;
              a_q         <= base_addr;
              next_addr_q <= base_addr + 14'd1;
              rem_q       <= len - 5'd1;
              state_q     <= (len == 5'd1) ? DRAIN : FETCH;
            end
          end
        end
        FETCH: begin
          if (can_issue) begin
            cs_b_q      <= 1'b0;
            oe_b_q      <= 1'b0;
            a_q         <= next_addr_q;
            next_addr_q <= next_addr_q + 14'd1;
            rem_q       <= rem_q - 5'd1;
            if (rem_q == 5'd1) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rom_data;
  end

`ifdef ALPHA_ROM_FETCH_CHKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      chk_q <= 8'h00;
    end else if ((state_q == IDLE) && start) begin
      chk_q <= 8'h00;
    end else if (pop) begin
      chk_q <= chk_q ^ out_data;
    end
  end

  assign checksum = chk_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_alpha_rom_fetch.sv
// tb/tb_alpha_rom_fetch.sv - directed self-checking bench for alpha_rom_fetch
module tb_alpha_rom_fetch;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start;
  logic [13:0] base_addr;
  logic [4:0]  len;
  logic [13:0] A;
  logic        CS_b;
  logic        OE_b;
  logic [7:0]  rom_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_busy = 0;
  int oe_bad   = 0;

  logic [13:0] iss_q [$];
  int          iss_cyc [$];
  logic [7:0]  rcv_q [$];

  alpha_rom_fetch #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .A         (A),
    .CS_b      (CS_b),
    .OE_b      (OE_b),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // ROM content mem[i] = i[7:0], registered one edge after the address.
  always @(posedge clk) rom_data <= A[7:0];

  always @(negedge clk) begin
    cyc++;
    if (reset_b) begin
      if (!CS_b) begin
        iss_q.push_back(A);
        iss_cyc.push_back(cyc);
      end
      if (OE_b !== CS_b) oe_bad++;
      if (out_valid && out_ready) rcv_q.push_back(out_data);
      if (done) begin
        done_cnt++;
        if (busy) done_busy++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_chk(input logic [7:0] x);
`ifdef ALPHA_ROM_FETCH_CHKSUM_EN
    return x;
`else
    return 8'h00;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    iss_q.delete();
    iss_cyc.delete();
    rcv_q.delete();
    done_cnt  = 0;
    done_busy = 0;
  endtask

  task automatic go(input logic [13:0] b, input logic [4:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step(1);
    end
    out_ready = 1'b1;
    step(2);
  endtask

  initial begin
    int bad;
    logic [7:0] x;
    logic [7:0] e;

    reset_b   = 1'b0;
    start     = 1'b0;
    base_addr = 14'h0;
    len       = 5'd0;
    out_ready = 1'b1;
    step(2);
    chk("rst_A", A, 14'h0);
    chk("rst_CS_b", CS_b, 1'b1);
    chk("rst_OE_b", OE_b, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_checksum", checksum, 8'h00);
    reset_b = 1'b1;
    step(2);

    // basic three-byte burst
    clear_logs();
    go(14'h0010, 5'd3);
    run_until_done(60, 1'b0);
    chk("b3_n_issue", iss_q.size(), 3);
    chk("b3_a0", iss_q[0], 14'h0010);
    chk("b3_a1", iss_q[1], 14'h0011);
    chk("b3_a2", iss_q[2], 14'h0012);
    chk("b3_consecutive", iss_cyc[2] - iss_cyc[0], 2);
    chk("b3_n_rcv", rcv_q.size(), 3);
    chk("b3_d0", rcv_q[0], 8'h10);
    chk("b3_d1", rcv_q[1], 8'h11);
    chk("b3_d2", rcv_q[2], 8'h12);
    chk("b3_done_cnt", done_cnt, 1);
    chk("b3_done_busy", done_busy, 0);
    chk("b3_checksum", checksum, exp_chk(8'h13));

    // address wrap at top of ROM
    clear_logs();
    go(14'h3FFE, 5'd4);
    run_until_done(60, 1'b0);
    chk("wr_n_issue", iss_q.size(), 4);
    chk("wr_a0", iss_q[0], 14'h3FFE);
    chk("wr_a1", iss_q[1], 14'h3FFF);
    chk("wr_a2", iss_q[2], 14'h0000);
    chk("wr_a3", iss_q[3], 14'h0001);
    chk("wr_n_rcv", rcv_q.size(), 4);
    chk("wr_d0", rcv_q[0], 8'hFE);
    chk("wr_d1", rcv_q[1], 8'hFF);
    chk("wr_d2", rcv_q[2], 8'h00);
    chk("wr_d3", rcv_q[3], 8'h01);
    chk("wr_checksum", checksum, exp_chk(8'h00));

    // backpressure: buffer fills, reads stall
    clear_logs();
    out_ready = 1'b0;
    go(14'h0040, 5'd10);
    step(19);
    chk("bp_n_issue", iss_q.size(), 4);
    chk("bp_CS_b", CS_b, 1'b1);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_data0", out_data, 8'h40);
    step(5);
    chk("bp_data_stable", out_data, 8'h40);
    chk("bp_n_issue_hold", iss_q.size(), 4);
    chk("bp_busy", busy, 1'b1);
    out_ready = 1'b1;
    run_until_done(80, 1'b0);
    chk("bp_n_issue_all", iss_q.size(), 10);
    chk("bp_n_rcv", rcv_q.size(), 10);
    bad = 0;
    for (int i = 0; i < rcv_q.size(); i++) if (rcv_q[i] !== 8'(8'h40 + i)) bad++;
    chk("bp_order", bad, 0);
    chk("bp_done_cnt", done_cnt, 1);

    // reset in the middle of a burst
    clear_logs();
    go(14'h0080, 5'd8);
    step(2);
    reset_b = 1'b0;
    #1;
    chk("mr_A", A, 14'h0);
    chk("mr_CS_b", CS_b, 1'b1);
    chk("mr_OE_b", OE_b, 1'b1);
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_data", out_data, 8'h00);
    chk("mr_busy", busy, 1'b0);
    chk("mr_done", done, 1'b0);
    chk("mr_checksum", checksum, 8'h00);
    step(1);
    reset_b = 1'b1;
    clear_logs();
    step(3);
    chk("mr_no_stale", rcv_q.size(), 0);
    go(14'h0020, 5'd2);
    run_until_done(60, 1'b0);
    chk("mr_n_issue", iss_q.size(), 2);
    chk("mr_n_rcv", rcv_q.size(), 2);
    chk("mr_d0", rcv_q[0], 8'h20);
    chk("mr_d1", rcv_q[1], 8'h21);
    chk("mr_checksum2", checksum, exp_chk(8'h01));

    // zero length start
    clear_logs();
    go(14'h0123, 5'd0);
    chk("z_done", done, 1'b1);
    chk("z_busy", busy, 1'b0);
    step(1);
    chk("z_done_drop", done, 1'b0);
    step(3);
    chk("z_n_issue", iss_q.size(), 0);
    chk("z_done_cnt", done_cnt, 1);

    // start while busy is ignored
    clear_logs();
    go(14'h0030, 5'd2);
    base_addr = 14'h0200;
    len       = 5'd5;
    start     = 1'b1;
    step(1);
    chk("ib_busy", busy, 1'b1);
    step(2);
    start = 1'b0;
    run_until_done(60, 1'b0);
    step(3);
    chk("ib_n_issue", iss_q.size(), 2);
    chk("ib_d0", rcv_q[0], 8'h30);
    chk("ib_d1", rcv_q[1], 8'h31);
    chk("ib_n_rcv", rcv_q.size(), 2);
    chk("ib_done_cnt", done_cnt, 1);

    // random backpressure over the longest burst
    clear_logs();
    go(14'h01F0, 5'd31);
    run_until_done(600, 1'b1);
    chk("rnd_n_rcv", rcv_q.size(), 31);
    chk("rnd_n_issue", iss_q.size(), 31);
    bad = 0;
    x   = 8'h00;
    for (int i = 0; i < 31; i++) begin
      e = 8'(8'hF0 + i);
      x = x ^ e;
      if (rcv_q[i] !== e) bad++;
    end
    chk("rnd_order", bad, 0);
    chk("rnd_done_cnt", done_cnt, 1);
    chk("rnd_checksum", checksum, exp_chk(x));

    chk("oe_tracks_cs", oe_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
